// File: rtl/parking_gate_scheduler.sv
// Parking gate scheduler: tick prescaler, entry/exit arbitration, occupancy tracking.
// Build option: define EXIT_PRIORITY_EN to make exit strictly beat entry.
module parking_gate_scheduler #(
   parameter int unsigned TICK_DIV   = 5_000_000,
   parameter int unsigned OPEN_TICKS = 4,
   parameter int unsigned CAPACITY   = 16
) (
   input  logic       CLK_IN,
   input  logic       RST_N,
   input  logic       ENTRY_REQ,
   input  logic       EXIT_REQ,
   output logic       ENTRY_GNT,
   output logic       EXIT_GNT,
   output logic       GATE_OPEN,
   output logic       BUSY,
   output logic [7:0] OCCUPANCY,
   output logic       LOT_FULL,
   output logic       TICK_OUT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_OPEN,
      S_CLOSE
   } state_t;

   localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
   localparam logic [7:0]  OPEN_LAST = 8'(OPEN_TICKS - 1);
   localparam logic [7:0]  CAP       = 8'(CAPACITY);

   state_t      state;
   logic [23:0] presc;
   logic [7:0]  open_cnt;
   logic        entry_ok;
   logic        exit_ok;
   logic        pick_entry;
   logic        pick_exit;
`ifndef EXIT_PRIORITY_EN
   logic        prefer_exit;
`endif

   // Free-running; never realigned by grants, so open time has up to one tick of jitter.
   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         presc <= '0;
      end else if (presc == TICK_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + 24'd1;
      end
   end

   assign TICK_OUT = (presc == TICK_LAST);
   assign BUSY     = (state != S_IDLE);
   assign LOT_FULL = (OCCUPANCY == CAP);

   always_comb begin
      entry_ok = ENTRY_REQ && (OCCUPANCY < CAP);
      exit_ok  = EXIT_REQ && (OCCUPANCY != 8'd0);
`ifdef EXIT_PRIORITY_EN
      pick_exit  = exit_ok;
      pick_entry = entry_ok && !exit_ok;
`else
      pick_exit  = exit_ok && (!entry_ok || prefer_exit);
      pick_entry = entry_ok && !pick_exit;
`endif
   end

   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         state       <= S_IDLE;
         open_cnt    <= '0;
         OCCUPANCY   <= '0;
         GATE_OPEN   <= 1'b0;
         ENTRY_GNT   <= 1'b0;
         EXIT_GNT    <= 1'b0;
`ifndef EXIT_PRIORITY_EN
         prefer_exit <= 1'b0;
`endif
      end else begin
         ENTRY_GNT <= 1'b0;
         EXIT_GNT  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_entry || pick_exit) begin
                  ENTRY_GNT <= pick_entry;
                  EXIT_GNT  <= pick_exit;
                  GATE_OPEN <= 1'b1;
                  state     <= S_OPEN;
                  open_cnt  <= '0;
                  if (pick_entry && (OCCUPANCY < CAP)) begin
                     OCCUPANCY <= OCCUPANCY + 8'd1;
                  end else if (pick_exit && (OCCUPANCY != 8'd0)) begin
                     OCCUPANCY <= OCCUPANCY - 8'd1;
                  end
`ifndef EXIT_PRIORITY_EN
                  prefer_exit <= pick_entry;
`endif
               end
            end
            S_OPEN: begin
               if (TICK_OUT) begin
                  if (open_cnt == OPEN_LAST) begin
                     state     <= S_CLOSE;
                     GATE_OPEN <= 1'b0;
                  end else begin
                     open_cnt <= open_cnt + 8'd1;
                  end
               end
            end
            S_CLOSE: begin
               state <= S_IDLE;
            end
            default: begin
               state     <= S_IDLE;
               GATE_OPEN <= 1'b0;
            end
         endcase
      end
   end

endmodule
